// File: rtl/seq_add64_ctrl_pkg.sv
// Shared constants and state encoding for the
// word-serial 64-bit adder/subtractor.
package seq_add64_ctrl_pkg;

   localparam int C_W     = 16;
   localparam int C_WORDS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/seq_add64_ctrl_rca16.sv
// 16-bit ripple-carry adder shared by every word
// of the serial 64-bit operation.
module RCA16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        carryInput,
   output logic [15:0] sum,
   output logic        carryOutput
);

   logic [16:0] w_c;

   // Single carry chain, bit 0 upward.
   always_comb begin
      w_c    = '0;
      sum    = '0;
      w_c[0] = carryInput;
      for (int i = 0; i < 16; i++) begin
         sum[i]   = a[i] ^ b[i] ^ w_c[i];
         w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
      carryOutput = w_c[16];
   end

endmodule

// File: rtl/seq_add64_ctrl.sv
// Word-serial 64-bit add/sub: one 16-bit adder
// reused over four RUN cycles, result on DONE.
module seq_add64_ctrl
   import seq_add64_ctrl_pkg::*;
#(
   parameter int WORDS = C_WORDS,
   parameter int W     = C_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sub,
   input  logic [WORDS*W-1:0] a,
   input  logic [WORDS*W-1:0] b,
   output logic               busy,
   output logic               done,
   output logic [WORDS*W-1:0] sum,
   output logic               carryOutput,
   output logic               overflow
);

   localparam int IW = $clog2(WORDS);
   localparam int N  = WORDS * W;

   state_t           r_state;
   state_t           w_next;
   logic             w_busy;
   logic             w_done;

   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic             r_sub;
   logic [IW-1:0]    r_idx;
   logic             r_carry;
   logic [N-1:0]     r_part;
   logic [N-1:0]     r_sum;
   logic             r_co;
   logic             r_ov;

   logic             w_accept;
   logic             w_last;
   logic [W-1:0]     w_a_word;
   logic [W-1:0]     w_b_word;
   logic             w_cin;
   logic [W-1:0]     w_sum;
   logic             w_co;
   logic [N-1:0]     w_result;
   logic             w_b_msb;

   assign w_accept = (r_state == IDLE) & start;
   assign w_last   = (r_idx == IW'(WORDS - 1));
   assign w_a_word = r_a[r_idx*W +: W];
   assign w_b_word = r_b[r_idx*W +: W] ^ {W{r_sub}};
   assign w_cin    = (r_idx == '0) ? r_sub : r_carry;
   assign w_b_msb  = r_b[N-1] ^ r_sub;

   RCA16 u_rca (
      .a           (w_a_word),
      .b           (w_b_word),
      .carryInput  (w_cin),
      .sum         (w_sum),
      .carryOutput (w_co)
   );

   // Full result with the word being computed now spliced in.
   always_comb begin
      w_result                 = r_part;
      w_result[r_idx*W +: W]   = w_sum;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next state and status outputs.
   always_comb begin
      w_next = r_state;
      w_busy = 1'b1;
      w_done = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (start) w_next = RUN;
         end
         RUN: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_busy = 1'b0;
            w_next = IDLE;
         end
      endcase
   end

   // Operand latch, per-word datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_part  <= '0;
         r_sum   <= '0;
         r_co    <= 1'b0;
         r_ov    <= 1'b0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= b;
         r_sub <= sub;
         r_idx <= '0;
      end else if (r_state == RUN) begin
         r_part[r_idx*W +: W] <= w_sum;
         r_carry              <= w_co;
         r_idx                <= r_idx + 1'b1;
         if (w_last) begin
            r_sum <= w_result;
            r_co  <= w_co;
            r_ov  <= ~(r_a[N-1] ^ w_b_msb) & (w_sum[W-1] ^ r_a[N-1]);
         end
      end
   end

   assign busy        = w_busy;
   assign done        = w_done;
   assign sum         = r_sum;
   assign carryOutput = r_co;
   assign overflow    = r_ov;

endmodule

// File: doc/seq_add64_ctrl.md
SEQ_ADD64_CTRL -- requirements
Module: seq_add64_ctrl

Interface
REQ-001 Parameter WORDS, 4, number of 16-bit words per operand (fixed at 4 in this release).
REQ-002 Parameter W, 16, word width; SHALL equal the width of the shared 16-bit ripple-carry adder.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 Port sub  input  1  0 = a+b, 1 = a-b; latched with start.
REQ-007 Port a  input  64  operand A; latched with start.
REQ-008 Port b  input  64  operand B; latched with start.
REQ-009 Port busy  output  1  high in RUN and DONE.
REQ-010 Port done  output  1  one-cycle pulse, result valid.
REQ-011 Port sum  output  64  registered result.
REQ-012 Port carryOutput  output  1  carry out of bit 63 (for sub: 1 = no borrow).
REQ-013 Port overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 FSM SHALL have states IDLE, RUN, DONE; IDLE→RUN on start; RUN→DONE after word WORDS-1; DONE→IDLE unconditionally.
REQ-015 On start accepted in IDLE, a, b, sub SHALL be latched; word index SHALL clear to 0.
REQ-016 Each RUN cycle SHALL process word i: adder a = a_reg[16i+15:16i], b = b_reg word XOR {16{sub_reg}}, carryInput = sub_reg when i==0 else carry register.
REQ-017 Each RUN cycle SHALL store adder sum into partial-result word i and adder carryOutput into the carry register; index increments by 1.
REQ-018 Latency: start sampled at edge T; words 0..3 computed at edges T+1..T+4; done high during the cycle after edge T+4 (start-to-done 5 edges).
REQ-019 sum, carryOutput, overflow SHALL update only on RUN→DONE transition and hold until the next accepted operation completes.
REQ-020 overflow SHALL equal (a_reg[63] XNOR b_eff[63]) AND (result[63] XOR a_reg[63]), b_eff = b_reg XOR {64{sub_reg}}.
REQ-021 start while busy (RUN or DONE) SHALL be ignored with no effect on latched operands.
REQ-022 start held high continuously SHALL start a new operation on each return to IDLE (one op per 6 cycles).
REQ-023 Exactly one adder instance SHALL be used; no second carry chain.

Reset
REQ-024 rst high at a clock edge SHALL force IDLE, busy=0, done=0, sum=0, carryOutput=0, overflow=0, index=0, carry register=0.
REQ-025 rst mid-RUN SHALL abort the operation; no done pulse SHALL follow; rst SHALL take priority over start.

Structure
REQ-026 Shared constants (W=16, WORDS=4, state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10) SHALL reside in the team's shared package/header.
REQ-027 The existing 16-bit ripple-carry adder RCA16 SHALL be the sole sub-module, instantiated unchanged.

Verification
REQ-028 Add a=64'h0000_0000_0000_FFFF, b=64'h1 → sum=64'h0000_0000_0001_0000, carryOutput=0, overflow=0, done exactly 5 edges after start.
REQ-029 Add a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1 → sum=0, carryOutput=1, overflow=0.
REQ-030 Sub a=5, b=7 → sum=64'hFFFF_FFFF_FFFF_FFFE, carryOutput=0, overflow=0; sub a=7, b=5 → sum=2, carryOutput=1.
REQ-031 Add a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → sum=64'h8000_0000_0000_0000, overflow=1, carryOutput=0.
REQ-032 start with a=1,b=1 then start with a=9,b=9 two cycles later (in RUN) → single done, sum=2, second request ignored.
REQ-033 rst asserted one cycle during RUN (word 2) → busy=0 next cycle, no done pulse, sum=0; subsequent start completes normally.
